device_cmd_dispatcher: RTL and testbench

//  Sequences 32-bit command words from the command FIFO (CLK domain) onto the shared device bus
//  (op/addr/data) for the ADC, DAC, timer and switch-group interfaces.

---
 rtl/device_cmd_dispatcher.sv | 213 +++++++++++++++++++++
 tb/tb_device_cmd_dispatcher.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/device_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : device_cmd_dispatcher
// Purpose  : Pulls 32-bit command words from the command FIFO, decodes the
//            target device slot, drives the shared device bus (op/addr/data),
//            pulses that slot's chip-select and waits for its ready with a
//            bounded timeout. ADC readbacks and error words are pushed into
//            the result FIFO.
// Ports    : clk, rst_n            - clock, async active-low reset
//            en                    - level enable (checked only in IDLE)
//            cmd_empty/cmd_rd/cmd_data - command FIFO read side
//            dev_cs/dev_rdy        - per-slot chip-select pulse / ready
//            dev_op/dev_addr/dev_data - latched shared device bus
//            adc_data              - ADC conversion result
//            res_wr/res_data/res_full - result FIFO write side
//            busy, err             - status (err is sticky until reset)
// Revision : 1.0 - initial release
// ============================================================================
module device_cmd_dispatcher #(
  parameter int N_DEV   = 7,
  parameter int TIMEOUT = 50000,
  parameter int ADC_DEV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmd_empty,
  output logic             cmd_rd,
  input  logic [31:0]      cmd_data,
  output logic [N_DEV-1:0] dev_cs,
  input  logic [N_DEV-1:0] dev_rdy,
  output logic [3:0]       dev_op,
  output logic [7:0]       dev_addr,
  output logic [15:0]      dev_data,
  input  logic [13:0]      adc_data,
  output logic             res_wr,
  output logic [15:0]      res_data,
  input  logic             res_full,
  output logic             busy,
  output logic             err
);

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

  localparam logic [3:0] CODE_WAIT_TO  = 4'd1;
  localparam logic [3:0] CODE_BAD_DEV  = 4'd2;
  localparam logic [3:0] CODE_ISSUE_TO = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5,
    S_RESULT = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  dev_q, dev_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [N_DEV-1:0] sel;
  logic             sel_rdy;
  logic [15:0]      cnt_inc;
  logic             cnt_at_limit;

  // One-hot decode of the latched slot; only meaningful once dev_q < N_DEV.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_DEV; i++) begin
      sel[i] = (dev_q == 4'(i));
    end
  end

  assign sel_rdy      = |(sel & dev_rdy);
  assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign cnt_at_limit = (cnt_q >= CNT_LIMIT);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    dev_d    = dev_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    cmd_rd   = 1'b0;
    dev_cs   = '0;
    res_wr   = 1'b0;
    res_data = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (en && !cmd_empty) state_d = S_FETCH;
      end

      S_FETCH: begin
        // Gate on !cmd_empty so the strobe can never underflow the FIFO.
        if (!cmd_empty) begin
          cmd_rd  = 1'b1;
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LATCH: begin
        dev_d  = cmd_data[3:0];
        op_d   = cmd_data[7:4];
        addr_d = cmd_data[15:8];
        data_d = cmd_data[31:16];
        if (cmd_data[3:0] == 4'd0) begin
          state_d = S_IDLE;
        end else if ({28'd0, cmd_data[3:0]} >= 32'(N_DEV)) begin
          code_d  = CODE_BAD_DEV;
          state_d = S_ERR;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (sel_rdy) begin
          dev_cs  = sel;
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end else if (cnt_at_limit) begin
          code_d  = CODE_ISSUE_TO;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT: begin
        // cnt_q == 0 is the first WAIT cycle: the device has not yet had a
        // chance to drop ready after the chip-select, so ignore it.
        if ((cnt_q != 16'd0) && sel_rdy) begin
          state_d = S_DONE;
        end else if (cnt_at_limit) begin
          code_d  = CODE_WAIT_TO;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        if ((dev_q == 4'(ADC_DEV)) && op_q[3]) state_d = S_RESULT;
        else                                   state_d = S_IDLE;
      end

      S_RESULT: begin
        if (!res_full) begin
          res_wr   = 1'b1;
          res_data = {2'b00, adc_data};
          state_d  = S_IDLE;
        end
      end

      S_ERR: begin
        err_d = 1'b1;
        if (!res_full) begin
          res_wr   = 1'b1;
          res_data = {4'hE, code_q, 4'h0, dev_q};
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) cnt_d = 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      addr_q  <= 8'd0;
      data_q  <= 16'd0;
      dev_q   <= 4'd0;
      code_q  <= 4'd0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dev_q   <= dev_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign dev_op   = op_q;
  assign dev_addr = addr_q;
  assign dev_data = data_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_device_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_device_cmd_dispatcher
// Purpose  : Scoreboard bench for device_cmd_dispatcher. Stimulus pushes
//            command words plus the expected chip-select / result words into
//            queues; a negedge monitor pops and compares whenever the DUT
//            pulses dev_cs or res_wr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_device_cmd_dispatcher;

  localparam int N_DEV   = 7;
  localparam int TIMEOUT = 100;
  localparam int ADC_DEV = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cmd_empty = 1'b1;
  logic             cmd_rd;
  logic [31:0]      cmd_data = 32'd0;
  logic [N_DEV-1:0] dev_cs;
  logic [N_DEV-1:0] dev_rdy;
  logic [3:0]       dev_op;
  logic [7:0]       dev_addr;
  logic [15:0]      dev_data;
  logic [13:0]      adc_data;
  logic             res_wr;
  logic [15:0]      res_data;
  logic             res_full;
  logic             busy;
  logic             err;

  device_cmd_dispatcher #(.N_DEV(N_DEV), .TIMEOUT(TIMEOUT), .ADC_DEV(ADC_DEV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmd_empty(cmd_empty), .cmd_rd(cmd_rd),
    .cmd_data(cmd_data), .dev_cs(dev_cs), .dev_rdy(dev_rdy), .dev_op(dev_op),
    .dev_addr(dev_addr), .dev_data(dev_data), .adc_data(adc_data), .res_wr(res_wr),
    .res_data(res_data), .res_full(res_full), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int rd_cyc = -100;
  int cs_cnt = 0;
  int wr_cnt = 0;

  logic [31:0] fifo    [$];
  logic [34:0] exp_cs  [$];
  logic [15:0] exp_res [$];
  logic [34:0] e_cs;
  logic [15:0] e_res;

  // Device models: ready drops the cycle after cs and returns lat[i] cycles later.
  int lat      [N_DEV];
  int dcnt     [N_DEV];
  bit hold_low [N_DEV];

  always @(posedge clk) begin
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_cs[i])        dcnt[i] <= lat[i];
      else if (dcnt[i] > 0) dcnt[i] <= dcnt[i] - 1;
    end
  end

  always_comb begin
    dev_rdy = '0;
    for (int i = 0; i < N_DEV; i++) dev_rdy[i] = (dcnt[i] == 0) && !hold_low[i];
  end

  // Command FIFO model: data valid the cycle after cmd_rd.
  always @(posedge clk) begin
    cyc++;
    if (cmd_rd) begin
      if (fifo.size() > 0) begin
        cmd_data <= fifo.pop_front();
      end else begin
        errors++;
        $display("FAIL cmd_rd_underflow: cmd_rd=1 required 0 (fifo empty)");
      end
    end
  end

  always @(negedge clk) cmd_empty = (fifo.size() == 0);

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_rd) begin
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (dev_cs != '0) begin
        cs_cnt++;
        checks++;
        if (exp_cs.size() == 0) begin
          errors++;
          $display("FAIL cs_unexpected: got cs=%b op=%h addr=%h data=%h required none",
                   dev_cs, dev_op, dev_addr, dev_data);
        end else begin
          e_cs = exp_cs.pop_front();
          if ({dev_cs, dev_op, dev_addr, dev_data} !== e_cs) begin
            errors++;
            $display("FAIL cs_word: got %h required %h",
                     {dev_cs, dev_op, dev_addr, dev_data}, e_cs);
          end
        end
        checks++;
        if (cyc - rd_cyc != 2) begin
          errors++;
          $display("FAIL cs_latency: got %0d required 2", cyc - rd_cyc);
        end
      end
      if (res_wr) begin
        wr_cnt++;
        checks++;
        if (res_full) begin
          errors++;
          $display("FAIL res_wr_while_full: res_wr=1 required 0");
        end
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected: got %h required none", res_data);
        end else begin
          e_res = exp_res.pop_front();
          if (res_data !== e_res) begin
            errors++;
            $display("FAIL res_word: got %h required %h", res_data, e_res);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic exp_c(input logic [6:0] cs, input logic [3:0] op,
                       input logic [7:0] addr, input logic [15:0] data);
    exp_cs.push_back({cs, op, addr, data});
  endtask

  task automatic wait_quiet(input string name);
    int q;
    q = 0;
    checks++;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (!busy && fifo.size() == 0) q++;
      else q = 0;
      if (q >= 3) return;
    end
    errors++;
    $display("FAIL %s: still busy after 2000 cycles, required idle", name);
  endtask

  task automatic wait_cs(input string name);
    checks++;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (dev_cs != '0) return;
    end
    errors++;
    $display("FAIL %s: no dev_cs within 500 cycles, required a pulse", name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base_rd, base_wr, base_cs, n;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    res_full = 1'b0;
    adc_data = 14'd0;
    lat[1] = 2; lat[2] = 3; lat[3] = 1000; lat[5] = 0;
    hold_low[4] = 1'b1;

    #23;
    chk("reset_outputs",
        {cmd_rd, dev_cs, res_wr, busy, err, dev_op, dev_addr, dev_data, res_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Single DAC command.
    @(posedge clk); #1;
    exp_c(7'b0000100, 4'h5, 8'h01, 16'h0ABC);
    fifo.push_back(32'h0ABC_0152);
    wait_cs("t1_cs");
    repeat (5) @(posedge clk);
    #1;
    chk("t1_busy_in_done", busy, 1);
    chk("t1_bus_stable", {dev_op, dev_addr, dev_data}, {4'h5, 8'h01, 16'h0ABC});
    @(posedge clk); #1;
    chk("t1_busy_after_done", busy, 0);
    wait_quiet("t1_idle");

    // ADC readback.
    adc_data = 14'h1234;
    base_wr  = wr_cnt;
    exp_c(7'b0000010, 4'h8, 8'h00, 16'h0000);
    exp_res.push_back(16'h1234);
    fifo.push_back(32'h0000_0081);
    wait_quiet("t2_idle");
    chk("t2_one_write", wr_cnt, base_wr + 1);

    // ADC readback against a full result FIFO.
    adc_data = 14'h2ABC;
    res_full = 1'b1;
    base_wr  = wr_cnt;
    exp_c(7'b0000010, 4'h8, 8'h00, 16'h0000);
    exp_res.push_back(16'h2ABC);
    fifo.push_back(32'h0000_0081);
    repeat (20) @(posedge clk);
    #1;
    chk("t2_held_busy", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_held_no_write", wr_cnt, base_wr);
    res_full = 1'b0;
    wait_quiet("t2b_idle");
    chk("t2_released_one_write", wr_cnt, base_wr + 1);

    // WAIT timeout on dev3.
    chk("t3_err_before", err, 0);
    exp_c(7'b0001000, 4'h1, 8'h33, 16'h1111);
    exp_res.push_back(16'hE103);
    fifo.push_back(32'h1111_3313);
    wait_cs("t3_cs");
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (res_wr) begin
        n = i;
        break;
      end
    end
    chk("t3_timeout_cycles", n, 101);
    wait_quiet("t3_idle");
    chk("t3_err_set", err, 1);
    base_cs = cs_cnt;
    exp_c(7'b0000100, 4'h7, 8'hAA, 16'h5555);
    fifo.push_back(32'h5555_AA72);
    wait_quiet("t3b_idle");
    chk("t3_next_cmd_runs", cs_cnt, base_cs + 1);
    chk("t3_err_sticky", err, 1);

    // ISSUE stall timeout on dev4 (never ready).
    base_cs = cs_cnt;
    exp_res.push_back(16'hE304);
    fifo.push_back(32'h0000_0014);
    wait_quiet("t3c_idle");
    chk("t3_stall_no_cs", cs_cnt, base_cs);

    // NOP then out-of-range device.
    base_cs = cs_cnt;
    base_rd = rd_cnt;
    exp_res.push_back(16'hE209);
    fifo.push_back(32'h0000_0000);
    fifo.push_back(32'h0000_0009);
    wait_quiet("t4_idle");
    chk("t4_no_cs", cs_cnt, base_cs);
    chk("t4_reads", rd_cnt, base_rd + 2);

    // en dropped during the second command's WAIT.
    base_rd = rd_cnt;
    exp_c(7'b0000100, 4'h2, 8'h10, 16'h1001);
    exp_c(7'b0000100, 4'h3, 8'h20, 16'h2002);
    exp_c(7'b0000100, 4'h4, 8'h30, 16'h3003);
    fifo.push_back(32'h1001_1022);
    fifo.push_back(32'h2002_2032);
    fifo.push_back(32'h3003_3042);
    wait_cs("t5_cs1");
    wait_cs("t5_cs2");
    @(posedge clk); #1;
    en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("t5_reads_while_disabled", rd_cnt, base_rd + 2);
    chk("t5_idle_while_disabled", busy, 0);
    en = 1'b1;
    wait_quiet("t5_idle");
    chk("t5_reads_after_enable", rd_cnt, base_rd + 3);

    // Async reset during WAIT.
    base_rd = rd_cnt;
    exp_c(7'b0000100, 4'h5, 8'h40, 16'h4004);
    exp_c(7'b0000100, 4'h6, 8'h50, 16'h5005);
    fifo.push_back(32'h4004_4052);
    fifo.push_back(32'h5005_5062);
    wait_cs("t6_cs");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outputs", {dev_cs, res_wr, busy, cmd_rd}, 0);
    chk("t6_err_cleared", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_quiet("t6_idle");
    chk("t6_reads", rd_cnt, base_rd + 2);
    chk("t6_fresh_word", {dev_op, dev_addr, dev_data}, {4'h6, 8'h50, 16'h5005});

    chk("end_cs_queue_empty", exp_cs.size(), 0);
    chk("end_res_queue_empty", exp_res.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
